// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-port memory arbiter.
// Requester 0 is controller fetch, 1 controller data, 2 external loader.
package mem_arb_pkg;

    localparam int NREQ = 3;

    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_LOAD  = 2;

    localparam int DEF_AW        = 8;
    localparam int DEF_DW        = 32;
    localparam int DEF_MAX_BURST = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE,
        LOCKED
    } state_t;

    // One-hot (3 bits) to index; only meaningful for one-hot input.
    function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] v);
        return {v[2], v[1]};
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-port bundle of the memory arbiter.
// slave is the arbiter's view, master the requesters'/memory's view.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    rw;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_rw;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    modport slave (
        input  req, lock, rw, req_addr, req_wdata, mem_rdata,
        output gnt, ack, rdata, mem_addr, mem_wdata, mem_rw, busy
    );

    modport master (
        output req, lock, rw, req_addr, req_wdata, mem_rdata,
        input  gnt, ack, rdata, mem_addr, mem_wdata, mem_rw, busy
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: first unmasked
// requester at or after ptr wins; output is one-hot.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    input  logic [NREQ-1:0] mask,
    output logic [NREQ-1:0] win
);
    logic [NREQ-1:0] r;

    assign r = req & ~mask;

    always_comb begin
        win = '0;
        unique case (ptr)
            2'd1: begin
                if (r[1])      win = 3'b010;
                else if (r[2]) win = 3'b100;
                else if (r[0]) win = 3'b001;
            end
            2'd2: begin
                if (r[2])      win = 3'b100;
                else if (r[0]) win = 3'b001;
                else if (r[1]) win = 3'b010;
            end
            default: begin
                if (r[0])      win = 3'b001;
                else if (r[1]) win = 3'b010;
                else if (r[2]) win = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of three requesters a
// single-port memory, with optional locked bursts per grant.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t          state, nxt;
    logic [NREQ-1:0] gnt_q, win, ack_c;
    logic [1:0]      own, ptr, sidx;
    logic [BW-1:0]   burst;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata, rdata_q;
    logic            lat_rw, mem_rw_c;
    logic            keep, take, rel;

    rr_pick u_pick (
        .req  (bus.req),
        .ptr  (ptr),
        .mask (ack_c),
        .win  (win)
    );

    // burst counts transactions of this grant, the first included
    assign keep = bus.lock[own] && (burst < BW'(MAX_BURST));
    assign take = (state == IDLE && |win)
               || (state == LOCKED && bus.req[own]);
    assign rel  = (state == DONE && !keep)
               || (state == LOCKED && !bus.req[own] && !bus.lock[own]);
    assign sidx = (state == IDLE) ? oh2idx(win) : own;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (|win) nxt = ISSUE;
            ISSUE:   nxt = CAPTURE;
            CAPTURE: nxt = DONE;
            DONE:    nxt = keep ? LOCKED : IDLE;
            LOCKED: begin
                if (bus.req[own])       nxt = ISSUE;
                else if (!bus.lock[own]) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            own       <= 2'd0;
            ptr       <= 2'd0;
            burst     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rw    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (take) begin
                lat_addr  <= bus.req_addr[int'(sidx)*AW +: AW];
                lat_wdata <= bus.req_wdata[int'(sidx)*DW +: DW];
                lat_rw    <= bus.rw[sidx];
            end
            if (state == IDLE && |win) begin
                gnt_q <= win;
                own   <= oh2idx(win);
                burst <= BW'(1);
            end else if (state == LOCKED && bus.req[own]
                         && burst < BW'(MAX_BURST)) begin
                burst <= burst + 1'b1;
            end
            if (state == CAPTURE && !lat_rw) rdata_q <= bus.mem_rdata;
            if (rel) begin
                gnt_q <= '0;
                ptr   <= (own == 2'd2) ? 2'd0 : own + 2'd1;
                burst <= '0;
            end
        end
    end

    always_comb begin
        ack_c    = '0;
        mem_rw_c = 1'b0;
        unique case (state)
            ISSUE:   mem_rw_c = lat_rw;
            DONE:    ack_c    = gnt_q;
            default: ;
        endcase
    end

    assign bus.ack       = ack_c;
    assign bus.mem_rw    = mem_rw_c;
    assign bus.gnt       = gnt_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.busy      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning memory address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning memory data width.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum number of consecutive locked transactions per grant.
REQ-004 The block SHALL have port clk, input, width 1, meaning the single clock; all logic is on posedge clk.
REQ-005 The block SHALL have port rst, input, width 1, meaning reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port req, input, width 3, meaning per-requester request (0=controller fetch, 1=controller data, 2=external loader).
REQ-007 The block SHALL have port lock, input, width 3, meaning per-requester burst lock.
REQ-008 The block SHALL have port rw, input, width 3, meaning per-requester direction (1=write, 0=read).
REQ-009 The block SHALL have port req_addr, input, width 3*AW, meaning packed addresses; requester i uses slice [i*AW +: AW].
REQ-010 The block SHALL have port req_wdata, input, width 3*DW, meaning packed write data, sliced the same way.
REQ-011 The block SHALL have port gnt, output, width 3, meaning one-hot current owner.
REQ-012 The block SHALL have port ack, output, width 3, meaning one-cycle completion pulse to the owner.
REQ-013 The block SHALL have port rdata, output, width DW, meaning read data, valid in the ack cycle.
REQ-014 The block SHALL have ports mem_addr (output, AW), mem_wdata (output, DW), mem_rw (output, 1) and mem_rdata (input, DW), meaning the memory port; the memory returns read data one cycle after the address.
REQ-015 The block SHALL have port busy, output, width 1, meaning the state is not IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, DONE and LOCKED.
REQ-017 In IDLE with any req high, the block SHALL pick the winner round-robin, starting from ptr; it SHALL latch that requester's addr, wdata and rw, set gnt, and go to ISSUE.
REQ-018 In ISSUE, the block SHALL drive mem_addr, mem_wdata and mem_rw from the latched values, then go to CAPTURE.
REQ-019 mem_rw SHALL be 1 in ISSUE only; in every other state it SHALL be 0 (read).
REQ-020 In CAPTURE, the block SHALL register rdata <= mem_rdata (reads only; writes leave rdata unchanged), register ack[owner]=1, and go to DONE.
REQ-021 Latency: req seen in IDLE at cycle N SHALL give mem access at N+1 and ack/rdata at N+3.
REQ-022 In DONE, with ack high: if lock[owner]=1 and the burst count is below MAX_BURST, the block SHALL go to LOCKED and keep gnt; otherwise it SHALL clear gnt, set ptr=(owner+1) mod 3, clear the burst count, and go to IDLE.
REQ-023 In LOCKED: if req[owner]=1, the block SHALL latch the new request, increment the burst count and go to ISSUE; if lock[owner]=0, it SHALL release exactly as in DONE; otherwise it SHALL stay in LOCKED. Other requesters SHALL be ignored in LOCKED.
REQ-024 The burst count SHALL saturate at MAX_BURST; reaching it SHALL force release at the next DONE regardless of lock.
REQ-025 A requester SHALL hold req, addr, wdata and rw stable until its ack; the arbiter SHALL ignore req of the acked requester in the ack cycle, so no duplicate grant occurs.
REQ-026 Changes to req or addr after latching SHALL NOT affect the transaction in flight.
REQ-027 Deassertion of req before ack SHALL NOT abort the transaction; it completes and acks.
REQ-028 ack SHALL be at most one-hot and never high outside DONE; gnt SHALL be at most one-hot.

Reset
REQ-029 On rst=1 at posedge clk, the block SHALL set state=IDLE, gnt=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_rw=0, ptr=0, burst count=0 and busy=0.
REQ-030 Reset mid-transaction (any state) SHALL abandon the transaction without ack; no write SHALL be issued in the cycle after reset.

Structure
REQ-031 A shared package mem_arb_pkg SHALL hold the state enum, NREQ=3, requester index constants (REQ_FETCH=0, REQ_DATA=1, REQ_LOAD=2) and default AW/DW/MAX_BURST.
REQ-032 The block SHALL contain one sub-module, rr_pick: a combinational 3-way round-robin picker taking req, ptr and mask and producing a one-hot winner.

Verification
REQ-033 Single read: req=001, rw=0, addr0=0x10, mem[0x10]=0xDEADBEEF -> mem_addr=0x10 at N+1, ack=001 and rdata=0xDEADBEEF at N+3, then busy=0.
REQ-034 Write: req=100, rw[2]=1, addr2=0x05, wdata2=0x12345678 -> mem_rw=1 for exactly one cycle with mem_addr=0x05, ack=100 at N+3, rdata unchanged.
REQ-035 Contention: req=111 held, each requester re-requesting after ack, ptr=0 -> grant order 0,1,2,0; no requester is acked twice in succession.
REQ-036 Lock burst: lock[1]=1 with 20 back-to-back reads, req[0] also high -> 16 consecutive acks to requester 1, forced release, next grant to requester 2 if requesting, else to requester 0.
REQ-037 Reset mid-op: rst=1 in CAPTURE of a write -> no ack, gnt=0, mem_rw=0, state IDLE next cycle; a fresh req then completes normally with N+3 latency.
REQ-038 Ack-cycle hold: the requester keeps req high through the ack cycle then drops it -> exactly one ack, no second grant.
